mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 23 ++
 rtl/mem_access_ctrl_if.sv | 41 ++++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the CPU-to-RAM access controller: bus widths,
// the controller state encoding and a wrapping counter helper.
package mem_ctrl_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    // Controller phases: wait for a request, pulse the RAM strobe,
    // take the read data, present the response.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Completed-transaction counter step; wraps from all-ones to zero.
    function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt);
        return cnt + 16'd1;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response channel of the memory access controller.
// The master modport is the requesting CPU, the slave modport the controller.
interface mem_access_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic signed [DATA_W-1:0] req_wdata;

    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_we;
    logic signed [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        input  resp_valid,
        output resp_ready,
        input  resp_we,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output resp_valid,
        input  resp_ready,
        output resp_we,
        output resp_rdata
    );

endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port RAM access controller. Accepts one CPU load/store at a time,
// pulses the RAM read or write strobe for exactly one cycle, captures load
// data one cycle later (RAM has a registered output) and holds the response
// until the CPU consumes it. Every output comes straight from a flop, so
// neither req_valid nor resp_ready reaches an output combinationally.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    mem_access_ctrl_if.slave         cpu,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic signed [DATA_W-1:0] mem_wdata,
    input  logic signed [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]         access_count
);

    state_e                   r_state;
    state_e                   w_next_state;
    logic                     w_accept;
    logic                     w_capture;
    logic                     w_complete;

    logic                     r_req_ready;
    logic                     r_resp_valid;
    logic                     r_resp_we;
    logic signed [DATA_W-1:0] r_resp_rdata;
    logic                     r_mem_rd;
    logic                     r_mem_wr;
    logic [ADDR_W-1:0]        r_mem_address;
    logic signed [DATA_W-1:0] r_mem_wdata;
    logic                     r_we;
    logic [CNT_W-1:0]         r_access_count;

    assign cpu.req_ready  = r_req_ready;
    assign cpu.resp_valid = r_resp_valid;
    assign cpu.resp_we    = r_resp_we;
    assign cpu.resp_rdata = r_resp_rdata;
    assign mem_address    = r_mem_address;
    assign mem_rd         = r_mem_rd;
    assign mem_wr         = r_mem_wr;
    assign mem_wdata      = r_mem_wdata;
    assign access_count   = r_access_count;

    // Next-state decode and the one-cycle event strobes for accept/capture/complete.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu.req_valid && r_req_ready) begin
                    w_next_state = ISSUE;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                // Stores have nothing to wait for; loads need the RAM output cycle.
                if (r_we) begin
                    w_next_state = RESP;
                end else begin
                    w_next_state = CAPTURE;
                end
            end
            CAPTURE: begin
                w_next_state = RESP;
                w_capture    = 1'b1;
            end
            RESP: begin
                if (cpu.resp_ready) begin
                    w_next_state = IDLE;
                    w_complete   = 1'b1;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake and RAM strobes, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
        end else begin
            r_req_ready  <= (w_next_state == IDLE);
            r_resp_valid <= (w_next_state == RESP);
            r_mem_rd     <= w_accept & ~cpu.req_we;
            r_mem_wr     <= w_accept &  cpu.req_we;
        end
    end

    // Request capture; address/data stay put between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we          <= 1'b0;
            r_resp_we     <= 1'b0;
            r_mem_address <= 7'd0;
            r_mem_wdata   <= 16'sd0;
        end else if (w_accept) begin
            r_we          <= cpu.req_we;
            r_resp_we     <= cpu.req_we;
            r_mem_address <= cpu.req_addr;
            r_mem_wdata   <= cpu.req_wdata;
        end else begin
            r_we          <= r_we;
            r_resp_we     <= r_resp_we;
            r_mem_address <= r_mem_address;
            r_mem_wdata   <= r_mem_wdata;
        end
    end

    // Load data is valid on the RAM output during CAPTURE; stores leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_rdata <= 16'sd0;
        end else if (w_capture) begin
            r_resp_rdata <= mem_rdata;
        end else begin
            r_resp_rdata <= r_resp_rdata;
        end
    end

    // Completed-transaction counter, stepped when the CPU takes a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_access_count <= 16'd0;
        end else if (w_complete) begin
            r_access_count <= count_next(r_access_count);
        end else begin
            r_access_count <= r_access_count;
        end
    end

endmodule
